// File: rtl/descrambler15.sv
// descrambler15 -- self-synchronizing serial descrambler, x^15 + x^14 + 1.
//
// Receive-side counterpart of the 15-bit scrambler. Recovers one payload
// bit per valid cycle, tracks whether the history register has been filled
// with enough received bits to be trusted, and, when enabled, checks an
// idle (all-zero) payload for bit errors with windowed loss-of-lock.
//
// Ports:
//   clk        clock, rising-edge
//   rst        synchronous, active-high reset
//   in_valid   in_bit is valid this cycle
//   in_bit     scrambled line bit
//   resync     single-cycle pulse restarting lock acquisition
//   chk_en     enables idle-pattern error checking while locked
//   clear_err  clears err_cnt (wins over a simultaneous increment)
//   out_valid  out_bit is valid (in_valid delayed one cycle)
//   out_bit    descrambled bit
//   locked     history register is filled and trusted
//   err_cnt    saturating count of checked error bits
module descrambler15 #(
    parameter int unsigned ERR_W      = 16,
    parameter int unsigned WIN_LEN    = 64,
    parameter int unsigned ERR_THRESH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             resync,
    input  logic             chk_en,
    input  logic             clear_err,
    output logic             out_valid,
    output logic             out_bit,
    output logic             locked,
    output logic [ERR_W-1:0] err_cnt
);

    typedef enum logic {
        FILL,
        LOCKED
    } state_t;

    state_t      state;
    logic [14:0] sr;
    logic [3:0]  fill_cnt;
    // Nine bits cover the full WIN_LEN / ERR_THRESH range of 2..256.
    logic [8:0]  win_cnt;
    logic [8:0]  win_err;

    logic descr;
    logic check;
    logic err;
    logic thresh_hit;

    always_comb begin
        descr      = in_bit ^ sr[13] ^ sr[14];
        // Accounting uses the state before the edge; a resync bit is never checked.
        check      = (state == LOCKED) && chk_en && in_valid && !resync;
        err        = check && descr;
        thresh_hit = err && ((win_err + 9'd1) == 9'(ERR_THRESH));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FILL;
            sr        <= '0;
            fill_cnt  <= '0;
            win_cnt   <= '0;
            win_err   <= '0;
            out_valid <= 1'b0;
            out_bit   <= 1'b0;
            locked    <= 1'b0;
            err_cnt   <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_bit <= descr;
                sr      <= {sr[13:0], in_bit};
            end

            if (clear_err) begin
                err_cnt <= '0;
            end else if (err && (err_cnt != '1)) begin
                err_cnt <= err_cnt + 1'b1;
            end

            if (resync) begin
                state    <= FILL;
                locked   <= 1'b0;
                fill_cnt <= '0;
                win_cnt  <= '0;
                win_err  <= '0;
            end else begin
                case (state)
                    FILL: begin
                        if (in_valid) begin
                            if (fill_cnt == 4'd14) begin
                                state    <= LOCKED;
                                locked   <= 1'b1;
                                fill_cnt <= '0;
                            end else begin
                                fill_cnt <= fill_cnt + 4'd1;
                            end
                        end
                    end
                    LOCKED: begin
                        if (thresh_hit) begin
                            state    <= FILL;
                            locked   <= 1'b0;
                            fill_cnt <= '0;
                            win_cnt  <= '0;
                            win_err  <= '0;
                        end else if (check) begin
                            if (win_cnt == 9'(WIN_LEN - 1)) begin
                                win_cnt <= '0;
                                win_err <= '0;
                            end else begin
                                win_cnt <= win_cnt + 9'd1;
                                win_err <= win_err + {8'd0, err};
                            end
                        end
                    end
                    default: begin
                        state  <= FILL;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
